xs_rom_req_arbiter: RTL and testbench

- Parametrised N-channel arbiter that multiplexes layer ROM fetch requests (OBJ, BACK1, BACK2, MAP, …) onto one SDRAM read port.
- Sits between the video layer blocks' sdr_addr/sdr_req/sdr_rdy/sdr_data interfaces and the SDRAM controller.
- Replaces the fixed one-port-per-layer wiring in the core top: round-robin fairness, per-channel request masking and an optional per-channel last-word cache.

---
 rtl/xs_rom_arb_pkg.sv | 11 +
 rtl/xs_rr_picker.sv | 31 +++
 rtl/xs_rom_req_arbiter.sv | 170 +++++++++++++++++
 tb/tb_xs_rom_req_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/xs_rom_arb_pkg.sv
// Shared types for the ROM request arbiter: FSM state encoding and channel-index width helper.
// Pure declarations, no logic.
package xs_rom_arb_pkg;

  typedef enum logic {IDLE, WAIT} state_t;

  function automatic int chidx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xs_rr_picker.sv
// Combinational round-robin picker: first eligible channel at or after ptr_i, wrapping modulo NCH.
// Zero latency; vld_o low when nothing is eligible.
module xs_rr_picker
  import xs_rom_arb_pkg::*;
#(
  parameter int NCH = 3,
  parameter int IW  = chidx_w(NCH)
) (
  input  logic [NCH-1:0] elig_i,
  input  logic [IW-1:0]  ptr_i,
  output logic [IW-1:0]  gnt_o,
  output logic           vld_o
);

  int idx;

  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!vld_o && elig_i[idx]) begin
        vld_o = 1'b1;
        gnt_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/xs_rom_req_arbiter.sv
// N-channel round-robin arbiter of layer ROM fetches onto one SDRAM read port; req->rdy = mem latency + 2.
// Define XS_ROM_CACHE_EN for a per-channel last-word cache (hits answer in 1 cycle, no grant).
module xs_rom_req_arbiter
  import xs_rom_arb_pkg::*;
#(
  parameter int NCH = 3,
  parameter int AW  = 25,
  parameter int DW  = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NCH*AW-1:0]       ch_addr,
  input  logic [NCH-1:0]          ch_req,
  output logic [NCH-1:0]          ch_rdy,
  output logic [NCH*DW-1:0]       ch_dout,
  output logic [AW-1:0]           mem_addr,
  output logic                    mem_req,
  input  logic                    mem_rdy,
  input  logic [DW-1:0]           mem_dout,
  output logic [$clog2(NCH)-1:0]  mem_ch,
  input  logic                    cache_flush
);

  localparam int IW = chidx_w(NCH);

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NCH-1:0]  mask_q;
  logic            mem_req_q, mem_req_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [IW-1:0]   mem_ch_q, mem_ch_d;
  logic [NCH-1:0]  ch_rdy_q, ch_rdy_d;
  logic [DW-1:0]   dout_q [NCH];
  logic [NCH-1:0]  dout_we;
  logic [DW-1:0]   dout_wd [NCH];
  logic [NCH-1:0]  hit;
  logic [DW-1:0]   hit_dat [NCH];
  logic [NCH-1:0]  elig;
  logic [IW-1:0]   gnt;
  logic            gnt_vld;

`ifdef XS_ROM_CACHE_EN
  logic [AW-1:0]   tag_q [NCH];
  logic [DW-1:0]   cdat_q [NCH];
  logic [NCH-1:0]  cvld_q;
  logic            fill;

  assign fill = (state_q == WAIT) && mem_rdy;

  // The channel currently in flight never hits; its completion owns ch_rdy/ch_dout.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NCH; i++) begin
      hit_dat[i] = cdat_q[i];
      hit[i] = ch_req[i] && !mask_q[i] && cvld_q[i] &&
               (ch_addr[i*AW +: AW] == tag_q[i]) &&
               !((state_q == WAIT) && (mem_ch_q == IW'(i)));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cvld_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        tag_q[i]  <= '0;
        cdat_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (fill && (mem_ch_q == IW'(i))) begin
          tag_q[i]  <= mem_addr_q;
          cdat_q[i] <= mem_dout;
          cvld_q[i] <= !cache_flush;
        end else if (cache_flush) begin
          cvld_q[i] <= 1'b0;
        end
      end
    end
  end
`else
  logic unused_flush;
  assign unused_flush = cache_flush;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NCH; i++) hit_dat[i] = '0;
  end
`endif

  assign elig = ch_req & ~mask_q & ~hit;

  xs_rr_picker #(.NCH(NCH), .IW(IW)) u_picker (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt),
    .vld_o  (gnt_vld)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_ch_d   = mem_ch_q;
    ch_rdy_d   = hit;
    dout_we    = hit;
    for (int i = 0; i < NCH; i++) dout_wd[i] = hit_dat[i];

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          for (int i = 0; i < NCH; i++)
            if (gnt == IW'(i)) mem_addr_d = ch_addr[i*AW +: AW];
          mem_ch_d  = gnt;
          mem_req_d = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (mem_rdy) begin
          mem_req_d = 1'b0;
          // Data lands even if the requester let go; only the pulse is suppressed.
          for (int i = 0; i < NCH; i++) begin
            if (mem_ch_q == IW'(i)) begin
              dout_we[i]  = 1'b1;
              dout_wd[i]  = mem_dout;
              ch_rdy_d[i] = ch_req[i];
            end
          end
          ptr_d   = (mem_ch_q == IW'(NCH - 1)) ? '0 : mem_ch_q + IW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      mask_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_ch_q   <= '0;
      ch_rdy_q   <= '0;
      for (int i = 0; i < NCH; i++) dout_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mask_q     <= ch_rdy_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_ch_q   <= mem_ch_d;
      ch_rdy_q   <= ch_rdy_d;
      for (int i = 0; i < NCH; i++)
        if (dout_we[i]) dout_q[i] <= dout_wd[i];
    end
  end

  assign ch_rdy   = ch_rdy_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign mem_ch   = mem_ch_q;

  for (genvar g = 0; g < NCH; g++) begin : g_dout
    assign ch_dout[g*DW +: DW] = dout_q[g];
  end

endmodule

// File: tb/tb_xs_rom_req_arbiter.sv
// Directed bench for xs_rom_req_arbiter (3 channels); cache steps run only with XS_ROM_CACHE_EN.
module tb_xs_rom_req_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [74:0] ch_addr;
  logic [2:0]  ch_req;
  logic [2:0]  ch_rdy;
  logic [47:0] ch_dout;
  logic [24:0] mem_addr;
  logic        mem_req;
  logic        mem_rdy;
  logic [15:0] mem_dout;
  logic [1:0]  mem_ch;
  logic        cache_flush;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  xs_rom_req_arbiter #(.NCH(3), .AW(25), .DW(16)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ch_addr     (ch_addr),
    .ch_req      (ch_req),
    .ch_rdy      (ch_rdy),
    .ch_dout     (ch_dout),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_rdy     (mem_rdy),
    .mem_dout    (mem_dout),
    .mem_ch      (mem_ch),
    .cache_flush (cache_flush)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a grant, check it, answer with one mem_rdy pulse, check completion.
  task automatic serve(input int ch, input logic [24:0] addr, input logic [15:0] dat);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    chk("grant_req", {63'd0, mem_req}, 64'd1);
    chk("grant_ch", {62'd0, mem_ch}, 64'(ch));
    chk("grant_addr", {39'd0, mem_addr}, {39'd0, addr});
    mem_rdy  = 1'b1;
    mem_dout = dat;
    tick();
    mem_rdy  = 1'b0;
    chk("done_rdy", {61'd0, ch_rdy}, 64'(3'b001 << ch));
    chk("done_dout", {48'd0, ch_dout[ch*16 +: 16]}, {48'd0, dat});
  endtask

  initial begin
    int age, pulses, consec;
    logic prev;

    RST         = 1'b1;
    ch_addr     = '0;
    ch_req      = '0;
    mem_rdy     = 1'b0;
    mem_dout    = '0;
    cache_flush = 1'b0;
    repeat (2) tick();
    RST = 1'b0;
    tick();

    chk("rst_ch_rdy", {61'd0, ch_rdy}, 64'd0);
    chk("rst_ch_dout", {16'd0, ch_dout}, 64'd0);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_mem_addr", {39'd0, mem_addr}, 64'd0);
    chk("rst_mem_ch", {62'd0, mem_ch}, 64'd0);

    // Single request on channel 1, memory latency 4
    ch_addr[25 +: 25] = 25'h000123;
    ch_req = 3'b010;
    tick();
    chk("t1_req", {63'd0, mem_req}, 64'd1);
    chk("t1_addr", {39'd0, mem_addr}, 64'h123);
    chk("t1_ch", {62'd0, mem_ch}, 64'd1);
    repeat (4) tick();
    chk("t1_no_early_rdy", {61'd0, ch_rdy}, 64'd0);
    chk("t1_req_held", {63'd0, mem_req}, 64'd1);
    mem_rdy  = 1'b1;
    mem_dout = 16'hBEEF;
    tick();
    mem_rdy  = 1'b0;
    chk("t1_rdy", {61'd0, ch_rdy}, 64'b010);
    chk("t1_dout", {48'd0, ch_dout[31:16]}, 64'hBEEF);
    chk("t1_req_low", {63'd0, mem_req}, 64'd0);
    ch_req = 3'b000;
    tick();
    chk("t1_pulse_one", {61'd0, ch_rdy}, 64'd0);
    chk("t1_no_regrant", {63'd0, mem_req}, 64'd0);

    // Channel 2 drops its request while in flight
    ch_addr[50 +: 25] = 25'h000222;
    ch_req = 3'b100;
    tick();
    chk("drop_ch", {62'd0, mem_ch}, 64'd2);
    ch_req = 3'b000;
    tick();
    mem_rdy  = 1'b1;
    mem_dout = 16'h5A5A;
    tick();
    mem_rdy  = 1'b0;
    chk("drop_no_rdy", {61'd0, ch_rdy}, 64'd0);
    chk("drop_dout", {48'd0, ch_dout[47:32]}, 64'h5A5A);
    chk("drop_req_low", {63'd0, mem_req}, 64'd0);

    // Contention: pointer now 0, expect 0,1,2 then 0 again
    ch_addr[0 +: 25]  = 25'h000100;
    ch_addr[25 +: 25] = 25'h000101;
    ch_addr[50 +: 25] = 25'h000102;
    ch_req = 3'b111;
    serve(0, 25'h000100, 16'h1111);
    ch_req[0] = 1'b0;
    tick();
    ch_req[0] = 1'b1;
    serve(1, 25'h000101, 16'h2222);
    ch_req[1] = 1'b0;
    serve(2, 25'h000102, 16'h3333);
    ch_req[2] = 1'b0;
    serve(0, 25'h000100, 16'h4444);
    ch_req = 3'b000;
    tick();

    // Reset in the middle of a transaction
    ch_addr[25 +: 25] = 25'h000333;
    ch_req = 3'b010;
    tick();
    chk("rw_req", {63'd0, mem_req}, 64'd1);
    #2;
    RST    = 1'b1;
    ch_req = 3'b000;
    #1;
    chk("rw_async_req", {63'd0, mem_req}, 64'd0);
    chk("rw_async_dout", {16'd0, ch_dout}, 64'd0);
    #1;
    RST = 1'b0;
    tick();
    mem_rdy  = 1'b1;
    mem_dout = 16'hDEAD;
    tick();
    mem_rdy  = 1'b0;
    chk("rw_late_rdy", {61'd0, ch_rdy}, 64'd0);
    chk("rw_late_dout", {16'd0, ch_dout}, 64'd0);
    chk("rw_late_req", {63'd0, mem_req}, 64'd0);

    // Held request on channel 0; memory answers in the 2nd cycle of mem_req
    ch_addr[0 +: 25] = 25'h0000AA;
    ch_req = 3'b001;
    age = 0;
    pulses = 0;
    consec = 0;
    prev = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (ch_rdy[0]) begin
        pulses++;
        if (prev) consec++;
      end
      prev = ch_rdy[0];
      if (mem_req) age++;
      else age = 0;
      mem_rdy  = (age == 2);
      mem_dout = 16'h1000 + 16'(c);
    end
    mem_rdy = 1'b0;
    ch_req  = 3'b000;
    chk("held_pulses", 64'(pulses), 64'd5);
    chk("held_consec", 64'(consec), 64'd0);
    chk("held_dout", {48'd0, ch_dout[15:0]}, 64'h1012);
    repeat (2) tick();

`ifdef XS_ROM_CACHE_EN
    ch_addr[0 +: 25] = 25'h0000A0;
    ch_req = 3'b001;
    serve(0, 25'h0000A0, 16'hCAFE);
    ch_req = 3'b000;
    tick();
    ch_req = 3'b001;
    tick();
    chk("hit_rdy", {61'd0, ch_rdy}, 64'b001);
    chk("hit_no_mem", {63'd0, mem_req}, 64'd0);
    chk("hit_dout", {48'd0, ch_dout[15:0]}, 64'hCAFE);
    ch_req = 3'b000;
    cache_flush = 1'b1;
    tick();
    cache_flush = 1'b0;
    ch_req = 3'b001;
    tick();
    chk("flush_miss_rdy", {61'd0, ch_rdy}, 64'd0);
    serve(0, 25'h0000A0, 16'hF00D);
    ch_req = 3'b000;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
